// File: rtl/cic_pkg.sv
// Shared CIC definitions: phase counter width and the register-growth rule.
// Used by both the interpolator and the decimator.
package cic_pkg;

    localparam int unsigned CNT_WIDTH = 16;

    // ceil(log2(factor^(sections-1))): bits of growth from the DC gain.
    function automatic int unsigned gain_bits(input int unsigned factor,
                                              input int unsigned sections);
        longint unsigned p;
        int unsigned     b;
        p = 64'd1;
        b = 0;
        for (int unsigned i = 1; i < sections; i++) begin
            p = p * 64'(factor);
        end
        while ((64'd1 << b) < p) begin
            b++;
        end
        return b;
    endfunction

    function automatic bit width_ok(input int unsigned in_w,
                                    input int unsigned out_w,
                                    input int unsigned factor,
                                    input int unsigned sections);
        return out_w >= in_w + gain_bits(factor, sections);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One low-rate comb section: dout = din - din(previous load).
module cic_comb_stage #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
        end else if (load) begin
            d_q <= din;
        end
    end

    assign dout = din - d_q;

endmodule

// File: rtl/cic_up.sv
// CIC interpolator: low-rate comb chain, zero-stuffing by FACTOR, high-rate
// integrator chain. All arithmetic wraps modulo 2^OUTPUT_WIDTH by design.
module cic_up
    import cic_pkg::*;
#(
    parameter int unsigned SECTIONS     = 3,
    parameter int unsigned FACTOR       = 5,
    parameter int unsigned INPUT_WIDTH  = 18,
    parameter int unsigned OUTPUT_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [INPUT_WIDTH-1:0]  filter_in,
    output logic                    ce_in,
    output logic [OUTPUT_WIDTH-1:0] filter_out,
    output logic                    ce_out
);

    if (!width_ok(INPUT_WIDTH, OUTPUT_WIDTH, FACTOR, SECTIONS)) begin : g_width_check
        $error("cic_up: OUTPUT_WIDTH too small for FACTOR^(SECTIONS-1) growth");
    end

    logic [CNT_WIDTH-1:0]    cur_count_q;
    logic [CNT_WIDTH-1:0]    cur_count_d;
    logic [INPUT_WIDTH-1:0]  in_q;
    logic [OUTPUT_WIDTH-1:0] comb_w [SECTIONS+1];
    logic [OUTPUT_WIDTH-1:0] u_c;
    logic [OUTPUT_WIDTH-1:0] acc_q  [SECTIONS];
    logic [OUTPUT_WIDTH-1:0] acc_d  [SECTIONS];
    logic [OUTPUT_WIDTH-1:0] out_q;
    logic                    ce_out_q;

    assign ce_in = clk_enable && (cur_count_q == '0);

    assign comb_w[0] = OUTPUT_WIDTH'($signed(in_q));

    for (genvar k = 0; k < SECTIONS; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(OUTPUT_WIDTH)
        ) u_comb (
            .clk  (clk),
            .reset(reset),
            .load (ce_in),
            .din  (comb_w[k]),
            .dout (comb_w[k+1])
        );
    end

    // Phase 1 is held while clk_enable is low, so the injection is never lost.
    assign u_c = (cur_count_q == CNT_WIDTH'(1)) ? comb_w[SECTIONS] : '0;

    always_comb begin
        cur_count_d = (cur_count_q == CNT_WIDTH'(FACTOR - 1)) ? '0
                                                             : cur_count_q + CNT_WIDTH'(1);
        acc_d[0] = acc_q[0] + u_c;
        for (int k = 1; k < SECTIONS; k++) begin
            acc_d[k] = acc_q[k] + acc_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_count_q <= '0;
            in_q        <= '0;
            out_q       <= '0;
            ce_out_q    <= 1'b0;
            for (int k = 0; k < SECTIONS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            ce_out_q <= clk_enable;
            if (clk_enable) begin
                cur_count_q <= cur_count_d;
                if (ce_in) begin
                    in_q <= filter_in;
                end
                for (int k = 0; k < SECTIONS; k++) begin
                    acc_q[k] <= acc_d[k];
                end
                out_q <= acc_q[SECTIONS-1];
            end
        end
    end

    assign filter_out = out_q;
    assign ce_out     = ce_out_q;

endmodule

// File: tb/tb_cic_up.sv
// Bench for cic_up: impulse-response convolution model checked every cycle,
// plus literal impulse/DC/reset expectations and a second parameter set.
module tb_cic_up;

    localparam int S    = 3;
    localparam int F    = 5;
    localparam int IW   = 18;
    localparam int OW   = 24;
    localparam int HLEN = S * (F - 1) + 1;
    localparam int LAT  = S + 1;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          clk_enable = 1'b1;
    logic [IW-1:0] filter_in  = '0;
    logic          ce_in;
    logic [OW-1:0] filter_out;
    logic          ce_out;

    logic [IW-1:0] filter_in2 = IW'(1000);
    logic          ce_in2;
    logic [19:0]   filter_out2;
    logic          ce_out2;

    cic_up u_dut (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .filter_in (filter_in),
        .ce_in     (ce_in),
        .filter_out(filter_out),
        .ce_out    (ce_out)
    );

    cic_up #(
        .SECTIONS    (2),
        .FACTOR      (4),
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(20)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .filter_in (filter_in2),
        .ce_in     (ce_in2),
        .filter_out(filter_out2),
        .ce_out    (ce_out2)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint x;
        int     t;
    } smp_t;

    longint        h [HLEN];
    smp_t          hist [$];
    smp_t          smp;
    int            n          = 0;
    logic [OW-1:0] exp_out    = '0;
    logic          exp_ce_out = 1'b0;
    int            ce1_cnt    = 0;
    int            ce2_cnt    = 0;
    int            checks     = 0;
    int            errors     = 0;

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: output = sum of captured samples times the CIC impulse
    // response (boxcar of length F convolved S times), delayed by LAT edges.
    always @(posedge clk) begin
        longint s;
        int     d;
        chk("ce_in", longint'(ce_in), longint'(clk_enable && (reset || (n % F == 0))));
        if (ce_in)  ce1_cnt++;
        if (ce_in2) ce2_cnt++;
        if (reset) begin
            hist.delete();
            n          = 0;
            exp_out    = '0;
            exp_ce_out = 1'b0;
        end else begin
            exp_ce_out = clk_enable;
            if (clk_enable) begin
                if (n % F == 0) begin
                    smp.x = longint'($signed(filter_in));
                    smp.t = n;
                    hist.push_back(smp);
                end
                s = 0;
                foreach (hist[i]) begin
                    d = n - hist[i].t - LAT;
                    if (d >= 0 && d < HLEN) s += hist[i].x * h[d];
                end
                while (hist.size() > 0 && (n - hist[0].t - LAT) >= HLEN - 1) begin
                    void'(hist.pop_front());
                end
                exp_out = OW'(s);
                n++;
            end
        end
        #1;
        chk("filter_out", longint'($signed(filter_out)), longint'($signed(exp_out)));
        chk("ce_out", longint'(ce_out), longint'(exp_ce_out));
    end

    task automatic cyc(input logic en, input logic [IW-1:0] din, input logic rst);
        @(negedge clk);
        clk_enable = en;
        filter_in  = din;
        reset      = rst;
        @(posedge clk);
        #2;
    endtask

    // Impulse of 100 at phase 0, enabled once every `gap` clocks.
    task automatic impulse(input int gap, input string tag);
        longint want [5] = '{100, 300, 600, 1000, 1500};
        int     e   = 0;
        int     idx = 0;
        logic   en;
        while (e <= 8 && idx < 100) begin
            en = (idx % gap == 0);
            cyc(en, (e == 0) ? IW'(100) : IW'(0), 1'b0);
            if (en) begin
                if (e >= 4) chk({tag, "_imp"}, longint'($signed(filter_out)), want[e-4]);
                e++;
            end else begin
                chk({tag, "_ce_out_gated"}, longint'(ce_out), 0);
            end
            idx++;
        end
    endtask

    initial begin
        longint tmp [HLEN];
        foreach (h[i]) h[i] = (i == 0) ? 1 : 0;
        for (int r = 0; r < S; r++) begin
            foreach (tmp[i]) begin
                tmp[i] = 0;
                for (int j = 0; j < F; j++) if (i - j >= 0) tmp[i] += h[i-j];
            end
            h = tmp;
        end

        repeat (3) cyc(1'b1, IW'(0), 1'b1);
        chk("rst_out", longint'($signed(filter_out)), 0);
        chk("rst_ce_out", longint'(ce_out), 0);

        impulse(1, "plain");

        repeat (2) cyc(1'b1, IW'(0), 1'b1);
        impulse(2, "gate");

        cyc(1'b1, IW'(0), 1'b1);
        repeat (40) cyc(1'b1, IW'(1000), 1'b0);
        chk("dc_pos", longint'($signed(filter_out)), 25000);
        repeat (7) cyc(1'b1, IW'(1000), 1'b0);
        chk("dc_pos_hold", longint'($signed(filter_out)), 25000);
        repeat (40) cyc(1'b1, IW'(-131072), 1'b0);
        chk("dc_neg", longint'($signed(filter_out)), -3276800);
        ce1_cnt = 0;
        repeat (20) cyc(1'b1, IW'(-131072), 1'b0);
        chk("ce_in_period", ce1_cnt, 4);
        chk("dc_neg_hold", longint'($signed(filter_out)), -3276800);

        cyc(1'b1, IW'(0), 1'b1);
        cyc(1'b1, IW'(500), 1'b0);
        repeat (3) cyc(1'b1, IW'(0), 1'b0);
        cyc(1'b1, IW'(0), 1'b1);
        chk("midrst_out", longint'($signed(filter_out)), 0);
        chk("midrst_ce_out", longint'(ce_out), 0);
        impulse(1, "post");
        repeat (10) cyc(1'b1, IW'(0), 1'b0);
        chk("post_residue", longint'($signed(filter_out)), 0);

        repeat (3000) cyc(($urandom % 4) != 0, IW'($urandom), ($urandom % 250) == 0);

        repeat (40) cyc(1'b1, IW'(0), 1'b0);
        chk("p2_dc", longint'($signed(filter_out2)), 4000);
        ce2_cnt = 0;
        repeat (12) cyc(1'b1, IW'(0), 1'b0);
        chk("p2_ce_in_period", ce2_cnt, 3);
        chk("p2_dc_hold", longint'($signed(filter_out2)), 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
